// File: rtl/core_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_regs_pkg
// Brief    : Register map, bus FSM states and byte-merge helper for the
//            counter peripheral bus front end.
// Revision : 1.0 - initial release
// ============================================================================
package core_regs_pkg;

  localparam logic [31:0] c_ID_VALUE = 32'h5045_5231;

  localparam int unsigned c_ADDR_COUNTER1   = 0;
  localparam int unsigned c_ADDR_COUNTER2   = 1;
  localparam int unsigned c_ADDR_IRQ_STATUS = 2;
  localparam int unsigned c_ADDR_IRQ_ENABLE = 3;
  localparam int unsigned c_ADDR_ID         = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    RESPOND = 2'd2
  } bus_state_t;

  // Enabled lanes take the new data, the rest keep the old word.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] new_word,
                                             input logic [3:0]  lanes);
    logic [31:0] w_result;
    w_result = old_word;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) w_result[8*i +: 8] = new_word[8*i +: 8];
    end
    return w_result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_bus_slave_irq_latch.sv
`default_nettype none
// ============================================================================
// Module   : irq_latch
// Brief    : Rising-edge sticky interrupt with W1C clear and enable mask.
// Revision : 1.0 - initial release
// ============================================================================
module irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic status_clr,
  input  logic enable_we,
  input  logic enable_wdata,
  output logic pending,
  output logic enable,
  output logic irqOut
);

  logic r_irq_prev;
  logic r_pending;
  logic r_enable;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_irq_prev <= 1'b0;
      r_pending  <= 1'b0;
      r_enable   <= 1'b0;
    end else begin
      r_irq_prev <= irq;
      // A fresh edge beats a simultaneous clear so no event is lost.
      if (irq && !r_irq_prev) r_pending <= 1'b1;
      else if (status_clr)    r_pending <= 1'b0;
      if (enable_we) r_enable <= enable_wdata;
    end
  end

  assign pending = r_pending;
  assign enable  = r_enable;
  assign irqOut  = r_pending & r_enable;

endmodule
`default_nettype wire

// File: rtl/core_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : core_bus_slave
// Brief    : Avalon-MM style register front end for the dual counter core.
// Revision : 1.0 - initial release
// ============================================================================
module core_bus_slave
  import core_regs_pkg::*;
#(
  parameter int          ADDR_W   = 3,
  parameter logic [31:0] ID_VALUE = c_ID_VALUE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid,
  output logic              waitrequest,
  input  logic [31:0]       counter1,
  input  logic [31:0]       counter2,
  input  logic              irq,
  output logic [31:0]       counter1In,
  output logic [31:0]       counter2In,
  output logic              counter1We,
  output logic              counter2We,
  output logic              counter1Re,
  output logic              counter2Re,
  output logic              irqOut
);

  bus_state_t        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_hold;
  logic [31:0]       w_rdata;
  logic              w_idle;
  logic              w_wr;
  logic              w_rd;
  logic              w_sel_c1;
  logic              w_sel_c2;
  logic              w_sel_status;
  logic              w_sel_enable;
  logic              w_status_clr;
  logic              w_enable_we;
  logic              w_pending;
  logic              w_enable;

  // Requests are only honoured in IDLE and never while reset is asserted.
  assign w_idle = (r_state == IDLE) && !reset;
  assign w_wr   = w_idle && write;
  assign w_rd   = w_idle && read && !write;

  assign w_sel_c1     = (address == ADDR_W'(c_ADDR_COUNTER1));
  assign w_sel_c2     = (address == ADDR_W'(c_ADDR_COUNTER2));
  assign w_sel_status = (address == ADDR_W'(c_ADDR_IRQ_STATUS));
  assign w_sel_enable = (address == ADDR_W'(c_ADDR_IRQ_ENABLE));

  assign counter1We = w_wr && w_sel_c1;
  assign counter2We = w_wr && w_sel_c2;
  assign counter1Re = w_rd && w_sel_c1;
  assign counter2Re = w_rd && w_sel_c2;

  assign counter1In = counter1We ? byte_merge(counter1, writedata, byteenable) : '0;
  assign counter2In = counter2We ? byte_merge(counter2, writedata, byteenable) : '0;

  assign w_status_clr = w_wr && w_sel_status && byteenable[0] && writedata[0];
  assign w_enable_we  = w_wr && w_sel_enable && byteenable[0];

  irq_latch u_irq (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .status_clr   (w_status_clr),
    .enable_we    (w_enable_we),
    .enable_wdata (writedata[0]),
    .pending      (w_pending),
    .enable       (w_enable),
    .irqOut       (irqOut)
  );

  always_comb begin
    w_rdata = '0;
    case (r_addr)
      ADDR_W'(c_ADDR_COUNTER1):   w_rdata = counter1;
      ADDR_W'(c_ADDR_COUNTER2):   w_rdata = counter2;
      ADDR_W'(c_ADDR_IRQ_STATUS): w_rdata = {31'b0, w_pending};
      ADDR_W'(c_ADDR_IRQ_ENABLE): w_rdata = {31'b0, w_enable};
      ADDR_W'(c_ADDR_ID):         w_rdata = ID_VALUE;
      default:                    w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_hold  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read && !write) begin
            r_addr  <= address;
            r_state <= CAPTURE;
          end
        end
        CAPTURE: begin
          r_hold  <= w_rdata;
          r_state <= RESPOND;
        end
        RESPOND: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign waitrequest   = !reset && (r_state != IDLE);
  assign readdatavalid = !reset && (r_state == RESPOND);
  assign readdata      = readdatavalid ? r_hold : '0;

endmodule
`default_nettype wire

// File: tb/tb_core_bus_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_bus_slave
// Brief    : Directed self-checking bench for core_bus_slave with a small
//            counter core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_bus_slave;
  import core_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        read, write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;
  logic [31:0] counter1, counter2;
  logic        irq;
  logic [31:0] counter1In, counter2In;
  logic        counter1We, counter2We, counter1Re, counter2Re, irqOut;

  int n_tests = 0;
  int n_fail  = 0;

  logic        s_we1, s_we2, s_wait, s_re1, s_re2;
  logic [31:0] s_in1, s_in2, s_acc1;
  logic [31:0] d;
  int          lat;
  int          cnt;

  always #5 clk = ~clk;

  core_bus_slave #(.ADDR_W(3), .ID_VALUE(32'h5045_5231)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .byteenable(byteenable), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .counter1(counter1), .counter2(counter2), .irq(irq),
    .counter1In(counter1In), .counter2In(counter2In),
    .counter1We(counter1We), .counter2We(counter2We),
    .counter1Re(counter1Re), .counter2Re(counter2Re), .irqOut(irqOut)
  );

  // Core model: counter1 free-runs, counter2 holds; both load on We.
  always_ff @(posedge clk) begin
    if (reset) begin
      counter1 <= '0;
      counter2 <= '0;
    end else begin
      counter1 <= counter1We ? counter1In : counter1 + 32'd1;
      if (counter2We) counter2 <= counter2In;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next();
    @(posedge clk); #1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] wd, input logic [3:0] be);
    write = 1'b1; address = a; writedata = wd; byteenable = be;
    @(negedge clk);
    s_we1 = counter1We; s_we2 = counter2We; s_in1 = counter1In; s_in2 = counter2In;
    s_wait = waitrequest;
    next();
    write = 1'b0; read = 1'b0; byteenable = 4'h0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] rd, output int l);
    read = 1'b1; address = a;
    @(negedge clk);
    s_wait = waitrequest; s_re1 = counter1Re; s_re2 = counter2Re; s_acc1 = counter1;
    next();
    read = 1'b0;
    l = -1; rd = '0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check("rd_busy_wait", waitrequest, 1'b1);
      if (readdatavalid) begin
        l = n; rd = readdata;
        break;
      end
    end
    next();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with a write held high: it must be ignored.
    reset = 1'b1; read = 1'b0; write = 1'b1; address = 3'd0;
    writedata = 32'hDEAD_BEEF; byteenable = 4'hF; irq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_rdv", readdatavalid, 1'b0);
    check("rst_wait", waitrequest, 1'b0);
    check("rst_we1", counter1We, 1'b0);
    check("rst_in1", counter1In, 32'h0);
    check("rst_irqout", irqOut, 1'b0);
    next();
    write = 1'b0; reset = 1'b0;
    next();

    bus_read(3'd4, d, lat);
    check("id_accept_wait", s_wait, 1'b0);
    check("id_data", d, 32'h5045_5231);
    check("id_lat", lat, 2);

    bus_write(3'd0, 32'h0000_1000, 4'hF);
    check("wr1_we", s_we1, 1'b1);
    check("wr1_in", s_in1, 32'h0000_1000);
    check("wr1_we2", s_we2, 1'b0);
    check("wr1_wait", s_wait, 1'b0);
    @(negedge clk);
    check("wr1_we_oneshot", counter1We, 1'b0);
    next();
    // Core shows 0x1000 then 0x1001 at acceptance; capture sees 0x1002.
    bus_read(3'd0, d, lat);
    check("rd1_re1", s_re1, 1'b1);
    check("rd1_re2", s_re2, 1'b0);
    check("rd1_data", d, 32'h0000_1002);
    check("rd1_data_vs_accept", d, s_acc1 + 32'd1);
    check("rd1_lat", lat, 2);

    bus_write(3'd1, 32'hAABB_CCDD, 4'hF);
    bus_write(3'd1, 32'h1122_3344, 4'b0011);
    check("part_we2", s_we2, 1'b1);
    check("part_in2", s_in2, 32'hAABB_3344);
    bus_write(3'd1, 32'h1122_3344, 4'b1000);
    check("part_hi_in2", s_in2, 32'h11BB_3344);
    bus_write(3'd1, 32'hFFFF_FFFF, 4'b0000);
    check("be0_we2", s_we2, 1'b1);
    check("be0_in2", s_in2, 32'h11BB_3344);

    bus_write(3'd4, 32'h0, 4'hF);
    bus_read(3'd4, d, lat);
    check("id_ro", d, 32'h5045_5231);

    irq = 1'b1;
    next();
    @(negedge clk);
    check("irq_pending", dut.u_irq.r_pending, 1'b1);
    check("irq_masked", irqOut, 1'b0);
    next();
    bus_write(3'd3, 32'h1, 4'h1);
    @(negedge clk);
    check("irq_enabled", irqOut, 1'b1);
    next();
    bus_write(3'd2, 32'h1, 4'h1);
    @(negedge clk);
    check("w1c_pending", dut.u_irq.r_pending, 1'b0);
    check("w1c_irqout", irqOut, 1'b0);
    repeat (3) next();
    @(negedge clk);
    check("level_no_reset", dut.u_irq.r_pending, 1'b0);
    next();
    bus_read(3'd2, d, lat);
    check("status_rd0", d, 32'h0);
    bus_read(3'd3, d, lat);
    check("enable_rd", d, 32'h1);

    irq = 1'b0;
    repeat (2) next();
    irq = 1'b1;
    bus_write(3'd2, 32'h1, 4'h1);
    @(negedge clk);
    check("setwins_pending", dut.u_irq.r_pending, 1'b1);
    check("setwins_irqout", irqOut, 1'b1);
    next();
    bus_read(3'd2, d, lat);
    check("status_rd1", d, 32'h1);

    // Simultaneous read+write: the write lands, the read gets no response.
    read = 1'b1;
    bus_write(3'd0, 32'h0000_0055, 4'hF);
    check("perr_we1", s_we1, 1'b1);
    check("perr_in1", s_in1, 32'h0000_0055);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (readdatavalid || waitrequest) cnt++;
    end
    check("perr_no_resp", cnt, 0);
    next();

    read = 1'b1; address = 3'd0;
    @(negedge clk);
    next();
    read = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rstmid_rdv", readdatavalid, 1'b0);
    next();
    reset = 1'b0;
    @(negedge clk);
    check("rstmid_wait", waitrequest, 1'b0);
    check("rstmid_fsm", 32'(dut.r_state), 32'(IDLE));
    cnt = 0;
    repeat (4) begin
      if (readdatavalid) cnt++;
      @(negedge clk);
    end
    check("rstmid_no_rdv", cnt, 0);
    next();

    bus_read(3'd6, d, lat);
    check("unmapped_data", d, 32'h0);
    check("unmapped_lat", lat, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/core_bus_slave.md
Name: core_bus_slave

Overview:
- Memory-mapped register front end that drives the counter peripheral core from the system bus side.
- Decodes Avalon-MM-style single-word reads and writes into the core's per-counter write and read strobes.
- Returns counter values to the bus with a fixed read latency.
- Converts the core's level irq into a sticky, maskable, write-1-to-clear interrupt for the system.

Parameters:
ADDR_W, 3, word address width (8 word slots).
ID_VALUE, 32'h5045_5231, constant returned by the ID register.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
address  in  ADDR_W  word address
read  in  1  read request
write  in  1  write request
writedata  in  32  write data
byteenable  in  4  byte lane enables for writedata
readdata  out  32  read data, valid only while readdatavalid=1
readdatavalid  out  1  one-cycle read response strobe
waitrequest  out  1  bus stall; request is accepted only in a cycle with waitrequest=0
counter1  in  32  core counter1 value
counter2  in  32  core counter2 value
irq  in  1  core interrupt level
counter1In  out  32  load value to core
counter2In  out  32  load value to core
counter1We  out  1  one-cycle load strobe
counter2We  out  1  one-cycle load strobe
counter1Re  out  1  one-cycle read strobe
counter2Re  out  1  one-cycle read strobe
irqOut  out  1  system interrupt = pending AND enable

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values:
  - Outputs: readdata=0, readdatavalid=0, waitrequest=0, all We/Re strobes=0, counterXIn=0, irqOut=0.
  - Internal: pending=0, enable=0, irqPrev=0, FSM=IDLE.
- Register map (word addresses):
  - 0 COUNTER1: RW.
  - 1 COUNTER2: RW.
  - 2 IRQ_STATUS: bit0 pending; write 1 to clear; bits 31:1 read 0.
  - 3 IRQ_ENABLE: bit0 RW; other bits read 0 and ignore writes.
  - 4 ID: RO, returns ID_VALUE.
  - 5-7: read 0; writes ignored.
- FSM states: IDLE, CAPTURE, RESPOND.
- IDLE:
  - waitrequest=0.
  - write=1: the write is applied this cycle; stay in IDLE; zero wait states.
  - read=1 with write=0: the read is accepted.
    - Address 0 or 1: pulse the matching counterXRe this same cycle.
    - Latch the address; go to CAPTURE.
  - read=1 and write=1 together: protocol error; the write is performed and the read is dropped, with no response.
- CAPTURE:
  - waitrequest=1.
  - Sample the selected register into the read holding register; go to RESPOND.
- RESPOND:
  - waitrequest=1; readdatavalid=1 for exactly this cycle; readdata=holding register; next state IDLE.
- Read latency: readdatavalid occurs exactly 2 cycles after the acceptance cycle. Minimum spacing between accepted reads is 3 cycles.
- Counter value captured: the value on counterX during CAPTURE, i.e. the core value one cycle after acceptance. The bench must expect acceptance-cycle value + 1 when no load intervenes.
- Counter writes:
  - counterXWe pulses for 1 cycle in the accept cycle.
  - counterXIn = byte-merge of writedata into the current counterX: enabled lanes take writedata, other lanes keep counterX as sampled that cycle.
  - byteenable=0 still pulses We, reloading the current value; this equals "hold for one cycle".
  - The core shows the loaded value on the next cycle.
- Interrupt logic:
  - irqPrev registers irq every cycle.
  - pending is set on a rising edge (irq=1, irqPrev=0).
  - A W1C write with byteenable[0]=1 and writedata[0]=1 clears pending.
  - Set and clear in the same cycle: set wins.
  - A level held high does not re-set pending after a clear.
  - irqOut is combinational from the pending and enable registers.
- Reset mid-transaction: a read in CAPTURE or RESPOND is abandoned and no readdatavalid is issued. A write in the reset cycle is ignored.

Decomposition:
- Shared package core_regs_pkg contains:
  - Address constants: ADDR_COUNTER1..ADDR_ID.
  - The bus FSM state enum: IDLE/CAPTURE/RESPOND.
  - The default ID_VALUE.
  - The byte-merge function.
- One sub-module: irq_latch, holding edge detect, the pending/enable registers, W1C logic, and irqOut.

Test Plan:
- Reset, then read ID -> readdatavalid exactly 2 cycles after acceptance; readdata=32'h5045_5231; waitrequest=1 in those 2 cycles.
- Write 32'h0000_1000 to addr 0, byteenable=4'hF -> counter1We=1 one cycle, counter1In=32'h1000. Read addr 0 immediately -> counter1Re pulses in the accept cycle; returned value = 32'h1000 + 2 (the read captures the counter one cycle after acceptance, and the counter has been counting since the load).
- Partial write: counter2=32'hAABB_CCDD at the write cycle, writedata=32'h1122_3344, byteenable=4'b0011 -> counter2In=32'hAABB_3344.
- Core irq rises with enable=0 -> pending=1, irqOut=0. Write IRQ_ENABLE=1 -> irqOut=1. Write IRQ_STATUS=1 while irq stays high -> pending=0, irqOut=0, no re-set.
- Rising irq edge in the same cycle as a W1C write -> pending=1 (set wins).
- Read accepted, then reset asserted in CAPTURE -> no readdatavalid; waitrequest=0 and FSM=IDLE the cycle after reset. Read of addr 6 -> readdata=0.
